// File: rtl/credit_pkg.sv
// Shared definitions for both ends of the credit-based flow-control link.

// Link-level check helper. A violated condition is reported and simulation carries on.
`define CREDIT_ASSERT(cond, msg) assert (cond) else $warning("credit link: %s", msg);

package credit_pkg;

    // Sender link state; receiver-side monitors decode the same encoding.
    typedef enum logic [1:0] {
        RESET   = 2'd0,
        WAIT_RX = 2'd1,
        ACTIVE  = 2'd2
    } sender_state_e;

endpackage

// File: rtl/credit_counter.sv
// Saturating credit counter with load/clear and a withhold-adjusted spendable count.
module credit_counter #(
    parameter  int MaxCredit  = 8,
    localparam int CountWidth = $clog2(MaxCredit + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [CountWidth-1:0] load_value,
    input  logic                  clear,
    input  logic                  inc,
    input  logic                  dec,
    input  logic [CountWidth-1:0] withhold,
    output logic [CountWidth-1:0] count,
    output logic [CountWidth-1:0] available,
    output logic                  overflow
);
    import credit_pkg::*;

    localparam logic [CountWidth-1:0] Max = CountWidth'(MaxCredit);

    logic [CountWidth-1:0] load_clamped;

    // Clamp the load value and derive the spendable count and overflow flag.
    always_comb begin
        load_clamped = (load_value > Max) ? Max : load_value;
        available    = (count > withhold) ? count - withhold : '0;
        overflow     = inc & ~dec & ~load & ~clear & (count == Max);
    end

    // Clear wins over load; simultaneous inc and dec cancel. dec is only ever
    // asserted while credits are available, so it cannot wrap below zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_clamped;
        end else if (inc && !dec) begin
            if (count != Max) count <= count + 1'b1;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/credit_sender.sv
// Transmitter end of the credit link: FSM, credit accounting and one-cycle output register.
module credit_sender #(
    parameter  int Width      = 8,
    parameter  int MaxCredit  = 8,
    localparam int CountWidth = $clog2(MaxCredit + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [Width-1:0]      push_data,
    output logic                  pop_sender_in_reset,
    input  logic                  pop_receiver_in_reset,
    output logic                  pop_valid,
    output logic [Width-1:0]      pop_data,
    input  logic                  pop_credit,
    input  logic [CountWidth-1:0] credit_initial,
    input  logic [CountWidth-1:0] credit_withhold,
    output logic [CountWidth-1:0] credit_count,
    output logic [CountWidth-1:0] credit_available
);
    import credit_pkg::*;

    sender_state_e state, state_next;
    logic          load, clear, inc, fire, overflow;

    // State register; RESET is held asynchronously and for one cycle after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RESET;
        else      state <= state_next;
    end

    // Next state plus the counter control strobes tied to link transitions.
    always_comb begin
        state_next          = state;
        load                = 1'b0;
        clear               = 1'b0;
        pop_sender_in_reset = 1'b0;
        case (state)
            RESET: begin
                pop_sender_in_reset = 1'b1;
                state_next          = WAIT_RX;
            end
            WAIT_RX: begin
                if (!pop_receiver_in_reset) begin
                    state_next = ACTIVE;
                    load       = 1'b1;
                end
            end
            ACTIVE: begin
                if (pop_receiver_in_reset) begin
                    state_next = WAIT_RX;
                    clear      = 1'b1;
                end
            end
            default: state_next = RESET;
        endcase
    end

    // Handshake: a beat goes only when a spendable credit exists. Returned
    // credits count only while the link is up.
    always_comb begin
        push_ready = (state == ACTIVE) && (credit_available != '0);
        fire       = push_valid & push_ready;
        inc        = pop_credit & (state == ACTIVE);
    end

    credit_counter #(.MaxCredit(MaxCredit)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_value (credit_initial),
        .clear      (clear),
        .inc        (inc),
        .dec        (fire),
        .withhold   (credit_withhold),
        .count      (credit_count),
        .available  (credit_available),
        .overflow   (overflow)
    );

    // Output register; a beat accepted as the link drops is not forwarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else begin
            pop_valid <= fire & ~clear;
            if (fire) pop_data <= push_data;
        end
    end

    // A credit returned while already at the ceiling is a receiver protocol error.
    always_ff @(posedge clk) begin
        if (rst) `CREDIT_ASSERT(!overflow, "credit returned at MaxCredit")
    end

endmodule

// File: doc/credit_sender.md
# credit_sender

Transmitter end of the credit-based flow-control link whose far end is the credit receiver. Accepts a valid/ready stream from upstream logic and forwards each beat to the receiver through a one-cycle register stage, spending one credit per beat. Tracks credits returned on `pop_credit` and exchanges reset status with the receiver. A beat is never sent without a credit.

## Interface
- `Width`, 8: data width in bits.
- `MaxCredit`, 8: credit counter ceiling, ≥1.
- `CountWidth`, $clog2(MaxCredit+1): derived, not overridable.

- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `push_valid`  in  1  upstream beat valid.
- `push_ready`  out  1  upstream beat accepted when `push_valid & push_ready`.
- `push_data`  in  Width  upstream beat payload.
- `pop_sender_in_reset`  out  1  tells the receiver this side is in reset.
- `pop_receiver_in_reset`  in  1  receiver reset status.
- `pop_valid`  out  1  beat to receiver; no back-pressure.
- `pop_data`  out  Width  beat payload.
- `pop_credit`  in  1  one credit returned per asserted cycle.
- `credit_initial`  in  CountWidth  credits loaded on link-up; clamped to MaxCredit.
- `credit_withhold`  in  CountWidth  credits reserved and not spendable; may change at any time.
- `credit_count`  out  CountWidth  current credit counter.
- `credit_available`  out  CountWidth  spendable credits.

## Operation
- FSM states: RESET, WAIT_RX, ACTIVE.
  - RESET: entered asynchronously while `rst`=0. Stays for one full cycle after `rst` release, then goes to WAIT_RX.
  - WAIT_RX: moves to ACTIVE in the first cycle `pop_receiver_in_reset` is sampled 0. On that edge, `credit_count` <= min(`credit_initial`, MaxCredit).
  - ACTIVE: if `pop_receiver_in_reset` is sampled 1, go to WAIT_RX. On that edge `credit_count` <= 0 and `pop_valid` <= 0.
- `pop_sender_in_reset` = 1 in RESET only.
- `push_ready` = (state==ACTIVE) & (`credit_available` != 0); combinational.
- `credit_available` = (`credit_count` > `credit_withhold`) ? `credit_count` − `credit_withhold` : 0.
- Counter update in ACTIVE: next = `credit_count` + `pop_credit` − fire, where fire = `push_valid & push_ready`.
  - Simultaneous fire and credit: count unchanged.
  - A credit arriving at count==0 is usable the next cycle, not the same cycle.
- Overflow: an increment at `credit_count`==MaxCredit with no fire saturates at MaxCredit. This is a protocol error and triggers an assertion.
- `pop_credit` is ignored outside ACTIVE.
- Output stage:
  - `pop_valid` <= fire.
  - `pop_data` <= `push_data` on fire; otherwise it holds its value.
- Reset values (all while `rst`=0): state RESET, `credit_count` 0, `credit_available` 0, `push_ready` 0, `pop_valid` 0, `pop_data` 0, `pop_sender_in_reset` 1.

## Timing
- Push-to-pop latency is 1 cycle. Throughput is one beat per cycle while credits last.
- After `rst` rises:
  - Cycle 0: RESET.
  - Cycle 1: WAIT_RX.
  - The earliest cycle `push_ready` can be 1 is cycle 2, if the receiver is already out of reset at cycle 1.
- A fire and its credit decrement take effect on the same edge, so `credit_available` reflects the beat in the following cycle.
- A beat registered on the same edge that the FSM leaves ACTIVE is dropped (`pop_valid` forced to 0). Upstream sees it as accepted.
- `credit_withhold` changes affect `push_ready` combinationally in the same cycle.

## Structure
- Shared package `credit_pkg`:
  - `sender_state_e` enum (RESET, WAIT_RX, ACTIVE), reused by receiver-side monitors.
  - Link-level assertion helper macros.
- One sub-module, `credit_counter`:
  - Saturating up/down counter with a load port.
  - Computes `credit_available` against the withhold value.
  - Reused by the receiver.
- Top level holds the FSM, the output register and the assertions.

## Test plan
- Reset handshake: hold `pop_receiver_in_reset`=1 for 5 cycles after `rst` release.
  - Expect `pop_sender_in_reset` 1→0 after 1 cycle.
  - Expect `push_ready`=0 until receiver release; `credit_count` loads `credit_initial`=4 on the release edge.
- Credit exhaustion: `credit_initial`=3, `push_valid` held with data 0x11,0x22,0x33,0x44.
  - Expect three pop beats in consecutive cycles, then `push_ready`=0 and `credit_count`=0.
  - One `pop_credit` pulse, then 0x44 pops two cycles later.
- Simultaneous fire and credit: `credit_count`=2, `pop_credit`=1 every cycle with continuous push.
  - Expect `credit_count` constant at 2 and 10 beats popped back-to-back.
- Withhold: `credit_count`=5, `credit_withhold`=5.
  - Expect `push_ready`=0 and `credit_available`=0.
  - With withhold=3, expect exactly 2 beats before stall.
- Receiver reset mid-stream: assert `pop_receiver_in_reset` during a fire.
  - Expect `pop_valid`=0 next cycle, `credit_count`=0, state WAIT_RX.
  - After release, count reloads `credit_initial`.
- Overflow and async reset:
  - `pop_credit` at `credit_count`=MaxCredit=8 → count stays 8, assertion fires.
  - Drop `rst` mid-cycle → all outputs take their reset values immediately, without waiting for a clock edge.
